// File: rtl/stepper_motion_ctrl.sv
// stepper_motion_ctrl: 2-phase stepper sequencer with a linear trapezoidal speed ramp.
// Build option: define STEPPER_HALF_STEP_EN for the 8-entry half-step coil table.
module stepper_motion_ctrl #(
  parameter int CNT_W        = 16,
  parameter int STEPS_W      = 16,
  parameter int POS_W        = 32,
  parameter int DUTY_W       = 8,
  parameter int START_PERIOD = 50000,
  parameter int MIN_PERIOD   = 1000,
  parameter int RAMP_DEC     = 500,
  parameter int RUN_DUTY     = 200,
  parameter int HOLD_DUTY    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // cmd_* transfers on a rising edge where cmd_valid && cmd_ready; cmd_ready is
  // registered and high only while idle, so a command offered during a move waits.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEPS_W-1:0]      cmd_steps,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic [3:0]              coil,
  output logic [DUTY_W-1:0]       duty,
  output logic                    step_pulse,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] pos,
  output logic [1:0]              state_dbg   // 0 IDLE, 1 ACCEL, 2 CRUISE, 3 DECEL
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEL  = 2'd1,
    S_CRUISE = 2'd2,
    S_DECEL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  START_P = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0]  MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  RAMP_P  = CNT_W'(RAMP_DEC);
  localparam logic [DUTY_W-1:0] RUN_D   = DUTY_W'(RUN_DUTY);
  localparam logic [DUTY_W-1:0] HOLD_D  = DUTY_W'(HOLD_DUTY);

  state_t                    state, state_nxt;
  logic [2:0]                phase, phase_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0]          cur_period, cur_nxt;
  logic [CNT_W-1:0]          target, target_nxt, cmd_target;
  logic [STEPS_W-1:0]        rem, rem_nxt;
  logic [STEPS_W-1:0]        ramp, ramp_nxt;
  logic                      dir, dir_nxt;
  logic                      zero_pend, zero_nxt;
  logic                      accept, step_ev, ready_nxt;
  logic signed [POS_W-1:0]   pos_nxt;

  function automatic logic [CNT_W-1:0] decel_period(input logic [CNT_W-1:0] p);
    logic [CNT_W:0] s;
    s = {1'b0, p} + {1'b0, RAMP_P};
    return (s > {1'b0, START_P}) ? START_P : s[CNT_W-1:0];
  endfunction

  // Saturates at the target instead of wrapping below zero.
  function automatic logic [CNT_W-1:0] accel_period(input logic [CNT_W-1:0] p,
                                                    input logic [CNT_W-1:0] tgt);
    if ({1'b0, p} > ({1'b0, tgt} + {1'b0, RAMP_P})) return p - RAMP_P;
    return tgt;
  endfunction

  function automatic logic [STEPS_W-1:0] ramp_down(input logic [STEPS_W-1:0] r);
    return (r == '0) ? '0 : r - STEPS_W'(1);
  endfunction

  function automatic logic [3:0] coil_pat(input logic [2:0] ph);
`ifdef STEPPER_HALF_STEP_EN
    case (ph)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0011;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b1100;
      3'd6:    return 4'b1000;
      default: return 4'b1001;
    endcase
`else
    case (ph)
      3'd0:    return 4'b0011;
      3'd1:    return 4'b0110;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1001;
      default: return 4'b0000;
    endcase
`endif
  endfunction

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    cnt_nxt    = cnt;
    cur_nxt    = cur_period;
    target_nxt = target;
    rem_nxt    = rem;
    ramp_nxt   = ramp;
    dir_nxt    = dir;
    pos_nxt    = pos;
    zero_nxt   = 1'b0;
    step_ev    = 1'b0;
    accept     = cmd_valid && cmd_ready;
    cmd_target = (cmd_period > MIN_P) ? cmd_period : MIN_P;
    cnt_inc    = cnt + CNT_W'(1);

    if (state == S_IDLE) begin
      if (accept) begin
        if (cmd_steps == '0) begin
          zero_nxt = 1'b1;
        end else begin
          target_nxt = cmd_target;
          cur_nxt    = (START_P > cmd_target) ? START_P : cmd_target;
          rem_nxt    = cmd_steps;
          ramp_nxt   = '0;
          cnt_nxt    = '0;
          dir_nxt    = cmd_dir;
          state_nxt  = (cur_nxt == cmd_target) ? S_CRUISE : S_ACCEL;
        end
      end
    end else begin
      if (cnt_inc >= cur_period) begin
        step_ev = 1'b1;
        cnt_nxt = '0;
        rem_nxt = rem - STEPS_W'(1);
        pos_nxt = dir ? pos + POS_W'(1) : pos - POS_W'(1);
`ifdef STEPPER_HALF_STEP_EN
        phase_nxt = phase + (dir ? 3'd1 : 3'd7);
`else
        phase_nxt = {1'b0, phase[1:0] + (dir ? 2'd1 : 2'd3)};
`endif
        if (rem_nxt == '0) begin
          state_nxt = S_IDLE;
        end else if ((state == S_ACCEL || state == S_CRUISE) && rem_nxt <= ramp) begin
          state_nxt = S_DECEL;
          cur_nxt   = decel_period(cur_period);
          ramp_nxt  = ramp_down(ramp);
        end else if (state == S_ACCEL) begin
          cur_nxt  = accel_period(cur_period, target);
          ramp_nxt = ramp + STEPS_W'(1);
          if (cur_nxt == target) state_nxt = S_CRUISE;
        end else if (state == S_DECEL) begin
          cur_nxt  = decel_period(cur_period);
          ramp_nxt = ramp_down(ramp);
        end
      end else begin
        cnt_nxt = cnt_inc;
      end
      // Abort acts on the post-step view, so a coincident step is never lost.
      if (abort && (state_nxt == S_ACCEL || state_nxt == S_CRUISE)) begin
        if (ramp_nxt < rem_nxt) rem_nxt = ramp_nxt;
        if (rem_nxt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DECEL;
          cur_nxt   = decel_period(cur_nxt);
          ramp_nxt  = ramp_down(ramp_nxt);
        end
      end
    end
    ready_nxt = (state == S_IDLE) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase      <= '0;
      cnt        <= '0;
      cur_period <= START_P;
      target     <= START_P;
      rem        <= '0;
      ramp       <= '0;
      dir        <= 1'b0;
      zero_pend  <= 1'b0;
      pos        <= '0;
      coil       <= '0;
      duty       <= '0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      cnt        <= cnt_nxt;
      cur_period <= cur_nxt;
      target     <= target_nxt;
      rem        <= rem_nxt;
      ramp       <= ramp_nxt;
      dir        <= dir_nxt;
      zero_pend  <= zero_nxt;
      pos        <= pos_nxt;
      step_pulse <= step_ev;
      cmd_ready  <= ready_nxt;
      busy       <= !ready_nxt;
      // busy lags the state by one cycle, which marks the completion cycle.
      done       <= zero_pend || (state == S_IDLE && busy);
      if (state != S_IDLE || busy) coil <= coil_pat(phase);
      if (state != S_IDLE)         duty <= RUN_D;
      else if (busy)               duty <= HOLD_D;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/stepper_motion_ctrl.md
Name: stepper_motion_ctrl

Overview:
Motion sequencer for a 2-phase bipolar stepper. It accepts move commands (step count, direction, target step period) over a valid/ready handshake. It generates the coil phase pattern with a linear trapezoidal speed ramp, tracks absolute position, and drives the duty setpoint fed to the per-coil PWM instances. It sits between command logic (buttons or host) and the PWM/H-bridge outputs on the GPIO header.

Parameters:
CNT_W, 16, width of step-period counter (clk cycles)
STEPS_W, 16, width of step count and ramp counters
POS_W, 32, width of signed position counter
DUTY_W, 8, width of duty setpoint (matches PWM SIZE)
START_PERIOD, 50000, period of first/last ramp step, in clk cycles
MIN_PERIOD, 1000, lower clamp for commanded period
RAMP_DEC, 500, period change per step while ramping
RUN_DUTY, 200, duty while moving
HOLD_DUTY, 64, duty while idle after a move

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_steps  in  STEPS_W  number of steps to move
cmd_dir  in  1  1 = forward (phase +1, pos +1), 0 = reverse
cmd_period  in  CNT_W  target cruise period in clk cycles
abort  in  1  request controlled stop
coil  out  4  {B-, A-, B+, A+} drive pattern
duty  out  DUTY_W  PWM duty setpoint
step_pulse  out  1  1-cycle pulse per step taken
busy  out  1  motion in progress
done  out  1  1-cycle pulse on move completion
pos  out  POS_W  signed absolute position, wraps mod 2^POS_W

Behaviour:
- Reset (async, rst_n=0): state IDLE; phase=0; coil=0000 (released); duty=0; busy=0; done=0; step_pulse=0; pos=0; cmd_ready=1. All outputs registered.
- States: IDLE, ACCEL, CRUISE, DECEL. cmd_ready=1 only in IDLE. busy=1 in all other states. Commands offered while busy are held off, not dropped.
- Accept (cycle 0): target = max(cmd_period, MIN_PERIOD); cur_period = max(START_PERIOD, target); rem = cmd_steps; ramp = 0; period counter cleared.
  - If cur_period == target, go to CRUISE; otherwise go to ACCEL.
  - From cycle 1: coil = pattern[phase]; duty = RUN_DUTY.
- cmd_steps == 0: accepted; no step, no state change beyond IDLE; done=1 at cycle 1; coil and duty unchanged.
- Step event: period counter reaches cur_period (first step at cycle cur_period after accept). On the event:
  - step_pulse=1 for that cycle.
  - phase advances ±1 mod table length; pos ±1; rem decrements.
  - coil shows the new pattern in the next cycle.
- Per step, in priority order:
  1. rem reaches 0: go to IDLE.
  2. In ACCEL or CRUISE with rem <= ramp: go to DECEL and apply the decel update.
  3. In ACCEL: cur_period = max(cur_period - RAMP_DEC, target), saturating with no underflow; ramp += 1; go to CRUISE when cur_period == target.
  4. In DECEL: cur_period = min(cur_period + RAMP_DEC, START_PERIOD); ramp decrements, saturating at 0.
- Completion: the cycle after the final step_pulse, done=1 for 1 cycle, busy=0, cmd_ready=1, duty=HOLD_DUTY; coil holds the last pattern (holding torque).
- Full-step table (two-phase-on), phases 0..3: 0011, 0110, 1100, 1001.
- abort:
  - In ACCEL or CRUISE: rem = min(rem, ramp); state goes to DECEL, or to IDLE with done if the result is 0.
  - Same cycle as a step event: the step is processed first, then abort applies to the updated rem.
  - In IDLE or DECEL: ignored.
- Reset mid-move: immediate return to reset values. pos is lost.

Optional Feature:
STEPPER_HALF_STEP_EN:
- Defined: 8-entry half-step table, phases 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Phase wraps mod 8; pos counts half-steps.
- Undefined: 4-entry full-step table above, phase mod 4. Phase and pos register widths are otherwise unchanged.

Test Plan:
All directed tests use START_PERIOD=20, RAMP_DEC=5, MIN_PERIOD=5.
1. Reset: assert rst_n=0 mid-cycle -> immediately coil=0000, duty=0, busy=0, cmd_ready=1, pos=0.
2. steps=3, dir=1, period=20 -> step_pulse at cycles 20, 40, 60; coil 0011→0110→1100→1001; done at cycle 61; pos=3; duty 200 then 64.
3. steps=10, period=3 (clamped to 5) -> step intervals 20, 15, 10, 5, 5, 5, 5, 10, 15, 20; state sequence ACCEL→CRUISE→DECEL→IDLE; done at cycle 111; pos=10.
4. steps=3, period=5 -> intervals 20, 15, 20 (no cruise); then steps=0 -> done at cycle 1, pos unchanged.
5. steps=100, period=5; abort held 1 cycle right after the 5th step_pulse (ramp=3) -> exactly 3 more steps at intervals 10, 15, 20; then done; pos=8. cmd_valid asserted during the move stays pending until cmd_ready.
6. dir=0 from pos=0, steps=2 -> pos=-2 (all ones minus 1); coil 1001→1100. With STEPPER_HALF_STEP_EN defined, dir=1, steps=3 -> coil 0011→0010→0110.
